// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared types and constants for the knight-tour command sequencer
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } tour_state_e;

  localparam logic [3:0] MOVE         = 4'b0100;
  localparam logic [3:0] MOVE_FANFARE = 4'b0101;

  localparam logic [7:0] N = 8'h00;
  localparam logic [7:0] W = 8'h3F;
  localparam logic [7:0] S = 8'h7F;
  localparam logic [7:0] E = 8'hBF;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  localparam logic [4:0] LAST_IDX = 5'd23;

  // Square count for a signed knight offset in -2..+2.
  function automatic logic [3:0] offset_mag(input logic signed [2:0] v);
    logic [2:0] m;
    m = v[2] ? 3'(-v) : 3'(v);
    return {1'b0, m};
  endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// rtl/tour_cmd_if.sv - UART, tour-solver and command-processor signals of tour_cmd
interface tour_cmd_if;

  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic        tour_go;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport slave (
    input  cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
  );

  modport master (
    output cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
  );

endinterface

// File: rtl/tour_move_decode.sv
// rtl/tour_move_decode.sv - one-hot knight move to vertical and horizontal commands
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o
);

  logic signed [2:0] dy;
  logic signed [2:0] dx;

  // Lowest set bit wins when the solver hands over more than one bit.
  always_comb begin
    dy = 3'sd0;
    dx = 3'sd0;
    casez (move_i)
      8'b???????1: begin dy =  3'sd2; dx =  3'sd1; end
      8'b??????10: begin dy =  3'sd2; dx = -3'sd1; end
      8'b?????100: begin dy =  3'sd1; dx = -3'sd2; end
      8'b????1000: begin dy = -3'sd1; dx = -3'sd2; end
      8'b???10000: begin dy = -3'sd2; dx = -3'sd1; end
      8'b??100000: begin dy = -3'sd2; dx =  3'sd1; end
      8'b?1000000: begin dy = -3'sd1; dx =  3'sd2; end
      8'b10000000: begin dy =  3'sd1; dx =  3'sd2; end
      default:     begin dy =  3'sd0; dx =  3'sd0; end
    endcase
  end

  assign vert_cmd_o = {MOVE, (dy[2] ? S : N), offset_mag(dy)};
  assign horz_cmd_o = {MOVE_FANFARE, (dx[2] ? W : E), offset_mag(dx)};

endmodule

// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - sequences 24 knight moves into vertical/horizontal commands, else passes UART commands through
module tour_cmd
  import tour_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  tour_cmd_if.slave  bus
);

  tour_state_e state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [7:0]  move_q, move_d;

  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;

  tour_move_decode u_decode (
    .move_i     (move_q),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
      move_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      move_q    <= move_d;
    end
  end

  // The move is captured on every transition into VERT so cmd stays put while it is offered.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    move_d    = move_q;
    case (state_q)
      IDLE: begin
        if (bus.tour_go) begin
          state_d   = VERT;
          mv_indx_d = 5'd0;
          move_d    = bus.move;
        end
      end
      VERT: begin
        if (bus.clr_cmd_rdy) state_d = WAIT_V;
      end
      WAIT_V: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        if (bus.clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        if (bus.send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
            move_d    = bus.move;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_ACK;
    case (state_q)
      IDLE: begin
        cmd              = bus.cmd_UART;
        cmd_rdy          = bus.cmd_rdy_UART;
        clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      VERT: begin
        cmd_rdy = 1'b1;
      end
      WAIT_V: begin
        cmd_rdy = 1'b0;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (mv_indx_q == LAST_IDX) resp = RESP_DONE;
      end
      default: begin
        cmd_rdy = 1'b0;
      end
    endcase
  end

  assign bus.cmd              = cmd;
  assign bus.cmd_rdy          = cmd_rdy;
  assign bus.clr_cmd_rdy_UART = clr_cmd_rdy_UART;
  assign bus.resp             = resp;
  assign bus.mv_indx          = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - self-checking bench for tour_cmd
module tb_tour_cmd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tour_cmd_if bus ();

  tour_cmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Tour seen as a count of commands issued (0..47) plus whether the current one was taken.
  bit         m_tour;
  int         m_cmd_no;
  bit         m_acked;
  logic [7:0] m_move;

  function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit vertical);
    int dyt[8];
    int dxt[8];
    int dy;
    int dx;
    int mag;
    logic [7:0] hd;
    dyt = '{2, 2, 1, -1, -2, -2, -1, 1};
    dxt = '{1, -1, -2, -2, -1, 1, 2, 2};
    dy = 0;
    dx = 0;
    for (int k = 7; k >= 0; k--) begin
      if (mv[k]) begin
        dy = dyt[k];
        dx = dxt[k];
      end
    end
    if (vertical) begin
      mag = (dy < 0) ? -dy : dy;
      hd  = (dy < 0) ? 8'h7F : 8'h00;
      return {4'h4, hd, 4'(mag)};
    end
    mag = (dx < 0) ? -dx : dx;
    hd  = (dx < 0) ? 8'h3F : 8'hBF;
    return {4'h5, hd, 4'(mag)};
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_tour   = 1'b0;
      m_cmd_no = 0;
      m_acked  = 1'b0;
      m_move   = 8'h00;
    end else if (!m_tour) begin
      if (bus.tour_go) begin
        m_tour   = 1'b1;
        m_cmd_no = 0;
        m_acked  = 1'b0;
        m_move   = bus.move;
      end
    end else if (!m_acked) begin
      if (bus.clr_cmd_rdy) m_acked = 1'b1;
    end else if (bus.send_resp) begin
      if (m_cmd_no == 47) begin
        m_tour = 1'b0;
      end else begin
        m_cmd_no++;
        m_acked = 1'b0;
        if (m_cmd_no % 2 == 0) m_move = bus.move;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [15:0] e_cmd;
      logic        e_rdy;
      logic        e_clr;
      logic [7:0]  e_resp;
      if (!m_tour) begin
        e_cmd  = bus.cmd_UART;
        e_rdy  = bus.cmd_rdy_UART;
        e_clr  = bus.clr_cmd_rdy;
        e_resp = 8'h5A;
      end else begin
        e_cmd  = exp_cmd(m_move, (m_cmd_no % 2) == 0);
        e_rdy  = !m_acked;
        e_clr  = 1'b0;
        e_resp = (m_acked && m_cmd_no == 47) ? 8'h5A : 8'hA5;
      end
      cmp("mdl_mv_indx", 16'(bus.mv_indx), 16'(m_cmd_no / 2));
      cmp("mdl_cmd_rdy", 16'(bus.cmd_rdy), 16'(e_rdy));
      cmp("mdl_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'(e_clr));
      cmp("mdl_resp", 16'(bus.resp), 16'(e_resp));
      if (e_rdy) cmp("mdl_cmd", bus.cmd, e_cmd);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] tab [24];

  initial begin
    tab = '{8'h08, 8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h41, 8'h00, 8'hC0, 8'h06, 8'h18, 8'h30, 8'h60, 8'h81,
            8'hFF, 8'h03, 8'h0C, 8'h90, 8'hA0, 8'h12, 8'h24, 8'h48};
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.tour_go      = 1'b0;
    bus.move         = 8'h00;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    rst = 1'b1;
    step();
    step();
    check_en = 1'b1;
    rst = 1'b0;
    #1;
    cmp("reset_resp", 16'(bus.resp), 16'h005A);
    cmp("reset_mv_indx", 16'(bus.mv_indx), 16'h0000);
    cmp("reset_cmd_rdy", 16'(bus.cmd_rdy), 16'h0000);

    // UART pass-through in IDLE
    bus.cmd_UART = 16'h2000;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    cmp("pt_cmd", bus.cmd, 16'h2000);
    cmp("pt_cmd_rdy", 16'(bus.cmd_rdy), 16'h0001);
    cmp("pt_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'h0001);
    step();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    cmp("pt_clr_uart_low", 16'(bus.clr_cmd_rdy_UART), 16'h0000);
    bus.cmd_rdy_UART = 1'b0;
    bus.cmd_UART = 16'h0000;

    // Single move, early send_resp ignored
    bus.move = 8'h01;
    bus.tour_go = 1'b1;
    step();
    bus.tour_go = 1'b0;
    #1;
    cmp("single_vert", bus.cmd, 16'h4002);
    cmp("single_rdy_latency", 16'(bus.cmd_rdy), 16'h0001);
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    #1;
    cmp("early_resp_ignored", 16'(bus.cmd_rdy), 16'h0001);
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    cmp("wait_v_rdy", 16'(bus.cmd_rdy), 16'h0000);
    cmp("wait_v_resp", 16'(bus.resp), 16'h00A5);
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    #1;
    cmp("single_horz", bus.cmd, 16'h5BF1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Full tour, direction coverage on the first move
    bus.move = tab[0];
    bus.tour_go = 1'b1;
    step();
    bus.tour_go = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      cmp("tour_mv_indx", 16'(bus.mv_indx), 16'(i));
      if (i == 0) cmp("dir_vert", bus.cmd, 16'h47F1);
      repeat (i % 3) step();
      bus.clr_cmd_rdy = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp = 1'b1;
      step();
      bus.send_resp = 1'b0;
      #1;
      if (i == 0) cmp("dir_horz", bus.cmd, 16'h53F2);
      if (i == 5) begin
        bus.tour_go = 1'b1;
        step();
        bus.tour_go = 1'b0;
        #1;
        cmp("go_in_horz_indx", 16'(bus.mv_indx), 16'd5);
        cmp("go_in_horz_rdy", 16'(bus.cmd_rdy), 16'h0001);
      end
      repeat (i % 2) step();
      bus.clr_cmd_rdy = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0;
      #1;
      cmp("wait_h_resp", 16'(bus.resp), (i == 23) ? 16'h005A : 16'h00A5);
      if (i < 23) bus.move = tab[i + 1];
      bus.send_resp = 1'b1;
      step();
      bus.send_resp = 1'b0;
    end
    #1;
    cmp("tour_end_resp", 16'(bus.resp), 16'h005A);
    cmp("tour_end_indx", 16'(bus.mv_indx), 16'd23);
    cmp("tour_end_rdy", 16'(bus.cmd_rdy), 16'h0000);

    // Held handshake, then reset in WAIT_V at index 7
    bus.move = 8'h10;
    bus.tour_go = 1'b1;
    step();
    bus.tour_go = 1'b0;
    #1;
    cmp("hold_start", bus.cmd, 16'h47F2);
    repeat (100) step();
    #1;
    cmp("hold_cmd", bus.cmd, 16'h47F2);
    cmp("hold_rdy", 16'(bus.cmd_rdy), 16'h0001);
    for (int i = 0; i < 7; i++) begin
      bus.clr_cmd_rdy = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b1;
      bus.send_resp = 1'b0;
      step();
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp = 1'b1;
      step();
      bus.send_resp = 1'b0;
    end
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    cmp("pre_rst_indx", 16'(bus.mv_indx), 16'd7);
    cmp("pre_rst_rdy", 16'(bus.cmd_rdy), 16'h0000);
    bus.cmd_UART = 16'h1234;
    bus.cmd_rdy_UART = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    cmp("mid_rst_resp", 16'(bus.resp), 16'h005A);
    cmp("mid_rst_indx", 16'(bus.mv_indx), 16'd0);
    cmp("mid_rst_cmd", bus.cmd, 16'h1234);
    cmp("mid_rst_rdy", 16'(bus.cmd_rdy), 16'h0001);
    bus.cmd_rdy_UART = 1'b0;
    bus.cmd_UART = 16'h0000;

    // Multi-bit move resolves to the lowest bit
    bus.move = 8'h41;
    bus.tour_go = 1'b1;
    step();
    bus.tour_go = 1'b0;
    #1;
    cmp("illegal_vert", bus.cmd, 16'h4002);
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    #1;
    cmp("illegal_horz", bus.cmd, 16'h5BF1);
    step();
    step();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
